// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the add (FU0), mul (FU1) and
// branch (FU2) functional units. Each FU pushes results into a private FIFO; one
// FIFO head per cycle is loaded into a registered CDB stage that the ROB,
// tag-clear logic and reservation stations observe.
// Build option: define CDB_OLDEST_FIRST_EN to grant the FIFO whose head is
// oldest relative to rob_head; otherwise FIFOs are served round-robin.
module cdb_arbiter #(
  parameter int NUM_FU    = 3,
  parameter int DATA_W    = 16,
  parameter int ROB_IDX_W = 3,
  parameter int QDEPTH    = 2
) (
  input  logic                        clk1,
  input  logic                        rst,
  input  logic [NUM_FU-1:0]           fu_valid,
  output logic [NUM_FU-1:0]           fu_ready,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx,
  input  logic [NUM_FU*4-1:0]         fu_rd,
  input  logic [NUM_FU*DATA_W-1:0]    fu_data,
  input  logic [ROB_IDX_W-1:0]        rob_head,
  input  logic                        cdb_ready,
  input  logic                        flush,
  output logic                        cdb_valid,
  output logic [ROB_IDX_W-1:0]        cdb_rob_idx,
  output logic [3:0]                  cdb_rd,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [1:0]                  cdb_src
);

  localparam int PTR_W = $clog2(QDEPTH);

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [3:0]           rd;
    logic [DATA_W-1:0]    data;
  } entry_t;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PTR_W:0]    wr_ptr [NUM_FU];
  logic [PTR_W:0]    rd_ptr [NUM_FU];
  entry_t            mem    [NUM_FU][QDEPTH];
  entry_t            in_ent [NUM_FU];
  entry_t            head   [NUM_FU];
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              slot_free;
  logic              grant_vld;
  logic              do_grant;
  logic [1:0]        grant;
  entry_t            sel_ent;

  // Unpack FU inputs and derive FIFO status; ready depends on stored count only.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      in_ent[i].rob  = fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      in_ent[i].rd   = fu_rd[i*4 +: 4];
      in_ent[i].data = fu_data[i*DATA_W +: DATA_W];
      head[i]        = mem[i][rd_ptr[i][PTR_W-1:0]];
      empty[i]       = (wr_ptr[i] == rd_ptr[i]);
      full[i]        = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                       (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
      fu_ready[i]    = ~full[i];
      push[i]        = fu_valid[i] & ~full[i] & ~flush;
    end
  end

  // The CDB register may take a new result when empty or being consumed.
  assign slot_free = ~cdb_valid | cdb_ready;

`ifdef CDB_OLDEST_FIRST_EN
  // Oldest-first select: smallest distance from rob_head wins, ties to lowest FU.
  always_comb begin
    logic [ROB_IDX_W-1:0] age;
    logic [ROB_IDX_W-1:0] best_age;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_vld = 1'b0;
    grant     = '0;
    best_age  = '1;
    age       = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      age = head[i].rob - rob_head;
      if (!empty[i] && (!grant_vld || age < best_age)) begin
        grant_vld = 1'b1;
        grant     = 2'(i);
        best_age  = age;
      end
    end
  end
`else
  logic [1:0] rr_ptr;
  logic       unused_rob_head;

  // rob_head only matters for oldest-first selection.
  assign unused_rob_head = ^rob_head;

  // Round-robin select: search from rr_ptr upward, wrapping to FU0.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant     = 2'(idx);
      end
    end
  end

  // Advance the round-robin pointer past the winner; hold it otherwise.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (do_grant) begin
      rr_ptr <= (grant == 2'(NUM_FU-1)) ? 2'd0 : grant + 2'd1;
    end
  end
`endif

  // Pop the winning FIFO and mux its head toward the CDB register.
  always_comb begin
    do_grant = slot_free & grant_vld & ~flush;
    sel_ent  = head[0];
    pop      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant == 2'(i)) begin
        sel_ent = head[i];
        pop[i]  = do_grant;
      end
    end
  end

  // FIFO storage write.
  // NOTE: the result storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk1) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) mem[i][wr_ptr[i][PTR_W-1:0]] <= in_ent[i];
    end
  end

  // FIFO pointers: flush empties every FIFO and drops that cycle's pushes.
  always_ff @(posedge clk1 or posedge rst) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // Registered CDB stage: load the winner when the slot is free, hold while stalled.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_rd      <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (slot_free) begin
      cdb_valid <= grant_vld;
      if (grant_vld) begin
        cdb_rob_idx <= sel_ent.rob;
        cdb_rd      <= sel_ent.rd;
        cdb_data    <= sel_ent.data;
        cdb_src     <= grant;
      end
    end
  end

endmodule
